// File: rtl/simon32_decrypt_core.sv
// Simon 32/64 block decryptor: forward key expansion into a local round-key file,
// then 32 inverse rounds in reverse key order, one per clock. Caches the last expanded key.
module simon32_decrypt_core #(
    parameter int          ROUNDS  = 32,
    parameter logic [61:0] Z0      = 62'b11111010001001010110000111001101111101000100101011000011100110,
    parameter logic [15:0] C_CONST = 16'hFFFC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] ct,
    input  logic [63:0] key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] pt,
    output logic        busy
);

    localparam int IW = $clog2(ROUNDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXPAND,
        S_ROUND,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [15:0]     x_q, x_d;
    logic [15:0]     y_q, y_d;
    logic [63:0]     key_q, key_d;
    logic            cached_q, cached_d;
    logic [15:0]     rk_q [ROUNDS];

    logic            hit;
    logic            load_key;
    logic            rk_we;
    logic [15:0]     km1, km3, km4, tmp_a, tmp_b, rk_new;
    logic [5:0]      z_idx;
    logic [15:0]     rk_cur, f_y;

    function automatic logic [15:0] rol16(input logic [15:0] w, input int unsigned n);
        return (w << n) | (w >> (16 - n));
    endfunction

    assign hit = cached_q && (key == key_q);

    // Key expansion: k[i] from k[i-1], k[i-3], k[i-4]; z0 is read MSB-first.
    always_comb begin
        km1    = rk_q[idx_q - IW'(1)];
        km3    = rk_q[idx_q - IW'(3)];
        km4    = rk_q[idx_q - IW'(4)];
        tmp_a  = rol16(km1, 13) ^ km3;
        tmp_b  = tmp_a ^ rol16(tmp_a, 15);
        z_idx  = 6'd61 - (6'(idx_q) - 6'd4);
        rk_new = km4 ^ C_CONST ^ tmp_b ^ {15'b0, Z0[z_idx]};
    end

    always_comb begin
        rk_cur = rk_q[idx_q];
        f_y    = (rol16(y_q, 1) & rol16(y_q, 8)) ^ rol16(y_q, 2);
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        x_d       = x_q;
        y_d       = y_q;
        key_d     = key_q;
        cached_d  = cached_q;
        rk_we     = 1'b0;
        load_key  = 1'b0;
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        busy      = (state_q == S_EXPAND) || (state_q == S_ROUND);
        pt        = (state_q == S_DONE) ? {x_q, y_q} : 32'h0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    x_d = ct[31:16];
                    y_d = ct[15:0];
                    if (hit) begin
                        state_d = S_ROUND;
                        idx_d   = IW'(ROUNDS - 1);
                    end else begin
                        // Key words are overwritten now, so the old cache entry is gone.
                        load_key = 1'b1;
                        key_d    = key;
                        cached_d = 1'b0;
                        state_d  = S_EXPAND;
                        idx_d    = IW'(4);
                    end
                end
            end
            S_EXPAND: begin
                rk_we = 1'b1;
                if (idx_q == IW'(ROUNDS - 1)) begin
                    cached_d = 1'b1;
                    state_d  = S_ROUND;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_ROUND: begin
                x_d = y_q;
                y_d = x_q ^ f_y ^ rk_cur;
                if (idx_q == IW'(0)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            key_q    <= '0;
            cached_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            x_q      <= x_d;
            y_q      <= y_d;
            key_q    <= key_d;
            cached_q <= cached_d;
        end
    end

    // Round-key file has no reset; its contents only matter once the cache flag is set.
    always_ff @(posedge clk) begin
        if (load_key) begin
            for (int j = 0; j < 4; j++) begin
                rk_q[j] <= key[16*j +: 16];
            end
        end else if (rk_we) begin
            rk_q[idx_q] <= rk_new;
        end
    end

endmodule
